shift_ram_ctrl: RTL

- Parametrised word store, NWORDS x NBITS_DATA, with a command port and a built-in serialiser/deserialiser.
- Words can be written or read in parallel, shifted out bit-serially, or assembled from a serial input and committed to a chosen word.
- Successor to the board-level 4x4 RAM and the 4-bit parallel/serial register; driven from SWI, observed on LED/LCD in top.

---
 rtl/shift_ram_pkg.sv | 24 ++
 rtl/shift_ram_ctrl_if.sv | 54 +++++
 rtl/shift_ram_serdes.sv | 59 +++++
 rtl/shift_ram_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/shift_ram_pkg.sv
// -----------------------------------------------------------------------------
// shift_ram_pkg
// Shared types for the shift_ram_ctrl word store.
//   cmd_op_t : command opcodes carried on cmd_op
//   state_t  : controller FSM states. The encoding is fixed because the
//              controller exposes it on dbg_state.
// -----------------------------------------------------------------------------
package shift_ram_pkg;

    typedef enum logic [1:0] {
        OP_WRITE     = 2'b00,
        OP_READ      = 2'b01,
        OP_SHIFT_OUT = 2'b10,
        OP_SHIFT_IN  = 2'b11
    } cmd_op_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SOUT   = 2'd1,
        S_SIN    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/shift_ram_ctrl_if.sv
// -----------------------------------------------------------------------------
// shift_ram_ctrl_if
// Command, read-back and serial signals of shift_ram_ctrl.
//
// Handshake: a command transfers on a rising clk_2 edge where
// cmd_valid && cmd_ready. The requester raises cmd_valid with stable
// cmd_op/cmd_addr/cmd_wdata and holds them until that edge; cmd_ready never
// depends on cmd_valid. rvalid, done and addr_err are one-cycle pulses with
// no back-pressure.
//
// Optional feature macro: SHIFT_RAM_MSB_FIRST_EN adds cmd_msb_first.
//
// Modports: master = requester (drives commands and ser_in),
//           slave  = shift_ram_ctrl.
// -----------------------------------------------------------------------------
interface shift_ram_ctrl_if #(
    parameter int NBITS_DATA = 4,
    parameter int NWORDS     = 4
);
    localparam int ADDR_W = $clog2(NWORDS);

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [NBITS_DATA-1:0] cmd_wdata;
`ifdef SHIFT_RAM_MSB_FIRST_EN
    logic                  cmd_msb_first;
`endif
    logic [NBITS_DATA-1:0] rdata;
    logic                  rvalid;
    logic                  ser_in;
    logic                  ser_out;
    logic                  ser_valid;
    logic                  done;
    logic                  addr_err;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, ser_in,
`ifdef SHIFT_RAM_MSB_FIRST_EN
        output cmd_msb_first,
`endif
        input  cmd_ready, rdata, rvalid, ser_out, ser_valid, done, addr_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, ser_in,
`ifdef SHIFT_RAM_MSB_FIRST_EN
        input  cmd_msb_first,
`endif
        output cmd_ready, rdata, rvalid, ser_out, ser_valid, done, addr_err
    );

endinterface

// File: rtl/shift_ram_serdes.sv
// -----------------------------------------------------------------------------
// shift_ram_serdes
// Shift register shared by SHIFT_OUT and SHIFT_IN, with bit counter,
// direction flag (captured on load) and a last-bit flag.
//
// Ports:
//   clk_2, reset_n   clock, synchronous active-low reset
//   load             parallel load of load_data; clears the counter and
//                    captures load_msb_first
//   shift_en         shift one position, inserting shift_in
//   sreg             current register contents
//   ser_bit          bit currently at the output end (LSB or MSB)
//   last             counter is at the final bit of the word
// -----------------------------------------------------------------------------
module shift_ram_serdes #(
    parameter int NBITS_DATA = 4
) (
    input  logic                  clk_2,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [NBITS_DATA-1:0] load_data,
    input  logic                  load_msb_first,
    input  logic                  shift_en,
    input  logic                  shift_in,
    output logic [NBITS_DATA-1:0] sreg,
    output logic                  ser_bit,
    output logic                  last
);
    localparam int              CNT_W    = $clog2(NBITS_DATA);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBITS_DATA - 1);

    logic [CNT_W-1:0] bit_cnt;
    logic             msb_first_q;

    always_ff @(posedge clk_2) begin
        if (!reset_n) begin
            sreg        <= '0;
            bit_cnt     <= '0;
            msb_first_q <= 1'b0;
        end else if (load) begin
            sreg        <= load_data;
            bit_cnt     <= '0;
            msb_first_q <= load_msb_first;
        end else if (shift_en) begin
            // Same register serves both directions: the bit leaving one end
            // is the one presented on ser_out, the new bit enters the other.
            if (msb_first_q) begin
                sreg <= {sreg[NBITS_DATA-2:0], shift_in};
            end else begin
                sreg <= {shift_in, sreg[NBITS_DATA-1:1]};
            end
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    assign ser_bit = msb_first_q ? sreg[NBITS_DATA-1] : sreg[0];
    assign last    = (bit_cnt == LAST_CNT);

endmodule

// File: rtl/shift_ram_ctrl.sv
// -----------------------------------------------------------------------------
// shift_ram_ctrl
// NWORDS x NBITS_DATA word store with parallel WRITE/READ and bit-serial
// SHIFT_OUT / SHIFT_IN through shift_ram_serdes.
//
// Ports:
//   clk_2      clock, all state changes on the rising edge
//   reset_n    synchronous active-low reset (memory array is not reset)
//   bus        shift_ram_ctrl_if.slave: command, read-back and serial signals
//   dbg_state  current FSM state (shift_ram_pkg::state_t encoding)
//
// Optional feature macro: SHIFT_RAM_MSB_FIRST_EN. When defined,
// bus.cmd_msb_first selects MSB-first serial order per command; otherwise
// serial transfers are LSB-first only.
// -----------------------------------------------------------------------------
module shift_ram_ctrl
    import shift_ram_pkg::*;
#(
    parameter int NBITS_DATA = 4,
    parameter int NWORDS     = 4
) (
    input  logic               clk_2,
    input  logic               reset_n,
    shift_ram_ctrl_if.slave    bus,
    output logic [1:0]         dbg_state
);
    localparam int ADDR_W = $clog2(NWORDS);

    localparam logic [1:0] ST_IDLE   = S_IDLE;
    localparam logic [1:0] ST_SOUT   = S_SOUT;
    localparam logic [1:0] ST_SIN    = S_SIN;
    localparam logic [1:0] ST_FINISH = S_FINISH;

    // One extra bit so NWORDS itself is representable for the range check.
    localparam logic [ADDR_W:0] NWORDS_W = (ADDR_W + 1)'(NWORDS);

    logic [1:0]            state;
    logic [NBITS_DATA-1:0] mem [NWORDS];
    logic [NBITS_DATA-1:0] rdata_q;
    logic                  rvalid_q;
    logic                  addr_err_q;
    logic [ADDR_W-1:0]     addr_q;
    logic                  sin_q;        // current serial op is SHIFT_IN

    cmd_op_t               op;
    logic                  accept;
    logic                  addr_ok;
    logic [NBITS_DATA-1:0] mem_word;
    logic                  msb_first;

    logic                  sd_load;
    logic [NBITS_DATA-1:0] sd_load_data;
    logic                  sd_shift;
    logic                  sd_in;
    logic [NBITS_DATA-1:0] sreg;
    logic                  ser_bit;
    logic                  last_bit;

    assign op       = cmd_op_t'(bus.cmd_op);
    assign accept   = bus.cmd_valid && (state == ST_IDLE);
    assign addr_ok  = ({1'b0, bus.cmd_addr} < NWORDS_W);
    assign mem_word = addr_ok ? mem[bus.cmd_addr] : '0;

`ifdef SHIFT_RAM_MSB_FIRST_EN
    assign msb_first = bus.cmd_msb_first;
`else
    assign msb_first = 1'b0;
`endif

    // SHIFT_OUT loads the addressed word, SHIFT_IN starts from zero.
    assign sd_load      = accept && addr_ok && ((op == OP_SHIFT_OUT) || (op == OP_SHIFT_IN));
    assign sd_load_data = (op == OP_SHIFT_OUT) ? mem_word : '0;
    assign sd_shift     = (state == ST_SOUT) || (state == ST_SIN);
    assign sd_in        = (state == ST_SIN) && bus.ser_in;

    shift_ram_serdes #(
        .NBITS_DATA (NBITS_DATA)
    ) u_serdes (
        .clk_2          (clk_2),
        .reset_n        (reset_n),
        .load           (sd_load),
        .load_data      (sd_load_data),
        .load_msb_first (msb_first),
        .shift_en       (sd_shift),
        .shift_in       (sd_in),
        .sreg           (sreg),
        .ser_bit        (ser_bit),
        .last           (last_bit)
    );

    // FSM and command decode
    always_ff @(posedge clk_2) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            addr_err_q <= 1'b0;
            addr_q     <= '0;
            sin_q      <= 1'b0;
        end else begin
            rvalid_q   <= 1'b0;
            addr_err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (!addr_ok) begin
                            // Accepted but dropped; a READ still answers with 0.
                            addr_err_q <= 1'b1;
                            if (op == OP_READ) begin
                                rdata_q  <= '0;
                                rvalid_q <= 1'b1;
                            end
                        end else begin
                            case (op)
                                OP_READ: begin
                                    rdata_q  <= mem_word;
                                    rvalid_q <= 1'b1;
                                end
                                OP_SHIFT_OUT: begin
                                    state <= ST_SOUT;
                                    sin_q <= 1'b0;
                                end
                                OP_SHIFT_IN: begin
                                    state  <= ST_SIN;
                                    sin_q  <= 1'b1;
                                    addr_q <= bus.cmd_addr;
                                end
                                default: ; // WRITE handled by the memory block
                            endcase
                        end
                    end
                end
                ST_SOUT, ST_SIN: begin
                    if (last_bit) begin
                        state <= ST_FINISH;
                    end
                end
                ST_FINISH: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Memory array: no reset, single write port. The SHIFT_IN commit happens
    // on the edge leaving FINISH, when no command can be accepted.
    always_ff @(posedge clk_2) begin
        if (reset_n) begin
            if (accept && addr_ok && (op == OP_WRITE)) begin
                mem[bus.cmd_addr] <= bus.cmd_wdata;
            end else if ((state == ST_FINISH) && sin_q) begin
                mem[addr_q] <= sreg;
            end
        end
    end

    assign bus.cmd_ready = (state == ST_IDLE);
    assign bus.rdata     = rdata_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.addr_err  = addr_err_q;
    assign bus.ser_valid = (state == ST_SOUT) || (state == ST_SIN);
    assign bus.ser_out   = (state == ST_SOUT) && ser_bit;
    assign bus.done      = (state == ST_FINISH);
    assign dbg_state     = state;

endmodule
